// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath: saturating add,
// 2x2 pooling window offsets and the pool sequencer state encoding.
package cnn_pkg;

  localparam int unsigned SAT_W = 32;

  // Window element k -> (row, col) offset: k=0 (0,0), 1 (0,1), 2 (1,0), 3 (1,1)
  localparam logic [3:0] WIN_ROW_OFS = 4'b1100;
  localparam logic [3:0] WIN_COL_OFS = 4'b1010;

  typedef enum logic [2:0] {
    POOL_IDLE,
    POOL_RD0,
    POOL_RD1,
    POOL_RD2,
    POOL_RD3,
    POOL_CMP,
    POOL_WR
  } pool_state_e;

  // Adds two sign-extended operands one bit wider than SAT_W and clamps the
  // result to the signed range of an out_w-bit value.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             out_w
  );
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    hi  = ((SAT_W+1)'(1) <<< (out_w - 1)) - (SAT_W+1)'(1);
    lo  = ~hi;
    if (sum > hi) begin
      return SAT_W'(hi);
    end else if (sum < lo) begin
      return SAT_W'(lo);
    end
    return SAT_W'(sum);
  endfunction

endpackage

// File: rtl/fmap_bank.sv
// One feature-map channel bank: synchronous RAM, one write port and two
// registered read ports with read enables so idle ports keep their data.
module fmap_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 784,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              re_a,
  input  logic [AW-1:0]     addr_a,
  output logic [DATA_W-1:0] data_a,
  input  logic              re_b,
  input  logic [AW-1:0]     addr_b,
  output logic [DATA_W-1:0] data_b
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
    if (re_a) begin
      data_a <= mem[addr_a];
    end
    if (re_b) begin
      data_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/fmap_pool_buffer.sv
// Per-channel feature-map buffer: saturating biased store, dual-port load,
// and an in-place 2x2/stride-2 max-pool (optional ReLU) across all banks.
module fmap_pool_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned VAL_W  = 16,
  parameter int unsigned MAP_H  = 28,
  parameter int unsigned MAP_W  = 28,
  parameter int unsigned CH     = 8,
  parameter int unsigned RELU   = 1,
  localparam int unsigned DEPTH = MAP_H * MAP_W,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 store,
  input  logic [CW-1:0]        ch_sel,
  input  logic [AW-1:0]        w_addr,
  input  logic [DATA_W-1:0]    bias,
  input  logic [VAL_W-1:0]     value,
  input  logic                 pool_start,
  output logic                 pool_busy,
  output logic                 pool_done,
  input  logic                 load,
  input  logic [AW-1:0]        addr1,
  input  logic [AW-1:0]        addr2,
  output logic [CH*DATA_W-1:0] rd_data1,
  output logic [CH*DATA_W-1:0] rd_data2,
  output logic                 rd_valid
);

  localparam int unsigned   WIN_R      = MAP_H / 2;
  localparam int unsigned   WIN_C      = MAP_W / 2;
  localparam logic [AW-1:0] LAST_R     = AW'(WIN_R - 1);
  localparam logic [AW-1:0] LAST_C     = AW'(WIN_C - 1);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(MAP_W);
  localparam logic [AW-1:0] DST_STRIDE = AW'(WIN_C);
  localparam logic [AW:0]   DEPTH_V    = (AW+1)'(DEPTH);
  localparam logic [CW:0]   CH_V       = (CW+1)'(CH);

  pool_state_e state_q;
  pool_state_e state_d;

  logic [AW-1:0] r_q;
  logic [AW-1:0] c_q;
  logic          last_win;
  logic          pool_rd;
  logic [1:0]    rd_k;
  logic          max_init;
  logic          max_upd;
  logic          pool_wr;
  logic [AW-1:0] pool_rd_addr;
  logic [AW-1:0] pool_wr_addr;

  logic              store_ok;
  logic              load_ok;
  logic [DATA_W-1:0] store_data;
  logic              a1_ok_q;
  logic              a2_ok_q;

  logic [CH*DATA_W-1:0] q_a_all;
  logic [CH*DATA_W-1:0] q_b_all;
  logic [CH*DATA_W-1:0] fresh1;
  logic [CH*DATA_W-1:0] fresh2;
  logic [CH*DATA_W-1:0] hold1_q;
  logic [CH*DATA_W-1:0] hold2_q;

  assign last_win = (r_q == LAST_R) && (c_q == LAST_C);

  // Pool sequencer state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= POOL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pool sequencer next-state and datapath controls
  always_comb begin
    state_d  = state_q;
    pool_rd  = 1'b0;
    rd_k     = 2'd0;
    max_init = 1'b0;
    max_upd  = 1'b0;
    pool_wr  = 1'b0;
    case (state_q)
      POOL_IDLE: begin
        if (pool_start) begin
          state_d = POOL_RD0;
        end
      end
      POOL_RD0: begin
        pool_rd = 1'b1;
        rd_k    = 2'd0;
        state_d = POOL_RD1;
      end
      POOL_RD1: begin
        pool_rd  = 1'b1;
        rd_k     = 2'd1;
        max_init = 1'b1;
        state_d  = POOL_RD2;
      end
      POOL_RD2: begin
        pool_rd = 1'b1;
        rd_k    = 2'd2;
        max_upd = 1'b1;
        state_d = POOL_RD3;
      end
      POOL_RD3: begin
        pool_rd = 1'b1;
        rd_k    = 2'd3;
        max_upd = 1'b1;
        state_d = POOL_CMP;
      end
      POOL_CMP: begin
        max_upd = 1'b1;
        state_d = POOL_WR;
      end
      POOL_WR: begin
        pool_wr = 1'b1;
        state_d = last_win ? POOL_IDLE : POOL_RD0;
      end
      default: state_d = POOL_IDLE;
    endcase
  end

  // Status flags: busy follows the sequencer, done pulses as it leaves the last window
  always_ff @(posedge clk) begin
    if (!rst) begin
      pool_busy <= 1'b0;
      pool_done <= 1'b0;
    end else begin
      pool_busy <= (state_d != POOL_IDLE);
      pool_done <= (state_q == POOL_WR) && last_win;
    end
  end

  // Window counters, row-major; an odd trailing row/column is never visited
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
      c_q <= '0;
    end else if (state_q == POOL_WR) begin
      if (c_q == LAST_C) begin
        c_q <= '0;
        r_q <= last_win ? '0 : r_q + AW'(1);
      end else begin
        c_q <= c_q + AW'(1);
      end
    end
  end

  assign pool_rd_addr = ((r_q << 1) + AW'(WIN_ROW_OFS[rd_k])) * ROW_STRIDE
                      + (c_q << 1) + AW'(WIN_COL_OFS[rd_k]);
  assign pool_wr_addr = r_q * DST_STRIDE + c_q;

  assign store_ok = store && !pool_busy && !pool_start
                 && ({1'b0, w_addr} < DEPTH_V) && ({1'b0, ch_sel} < CH_V);
  assign load_ok  = load && !pool_busy;
  assign store_data = DATA_W'(sat_add(SAT_W'($signed(value)),
                                      SAT_W'($signed(bias)), DATA_W));

  // Load bookkeeping: valid strobe and per-port out-of-range masking
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      a1_ok_q  <= 1'b0;
      a2_ok_q  <= 1'b0;
    end else begin
      rd_valid <= load_ok;
      if (load_ok) begin
        a1_ok_q <= ({1'b0, addr1} < DEPTH_V);
        a2_ok_q <= ({1'b0, addr2} < DEPTH_V);
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_bank
    logic                     we;
    logic [AW-1:0]            wa;
    logic [DATA_W-1:0]        wd;
    logic [DATA_W-1:0]        q_a;
    logic [DATA_W-1:0]        q_b;
    logic signed [DATA_W-1:0] max_q;
    logic [DATA_W-1:0]        pooled;

    assign pooled = ((RELU != 0) && max_q[DATA_W-1]) ? '0 : max_q;
    assign we     = pool_wr || (store_ok && (ch_sel == CW'(g)));
    assign wa     = pool_wr ? pool_wr_addr : w_addr;
    assign wd     = pool_wr ? pooled : store_data;

    fmap_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
    ) u_bank (
      .clk    (clk),
      .we     (we),
      .w_addr (wa),
      .w_data (wd),
      .re_a   (load_ok || pool_rd),
      .addr_a (pool_rd ? pool_rd_addr : addr1),
      .data_a (q_a),
      .re_b   (load_ok),
      .addr_b (addr2),
      .data_b (q_b)
    );

    // Running window max; first element of each window seeds it
    always_ff @(posedge clk) begin
      if (max_init) begin
        max_q <= $signed(q_a);
      end else if (max_upd && ($signed(q_a) > max_q)) begin
        max_q <= $signed(q_a);
      end
    end

    assign q_a_all[g*DATA_W +: DATA_W] = q_a;
    assign q_b_all[g*DATA_W +: DATA_W] = q_b;
  end

  assign fresh1 = a1_ok_q ? q_a_all : '0;
  assign fresh2 = a2_ok_q ? q_b_all : '0;

  // Last delivered load result, so pool traffic on port A never leaks out
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold1_q <= '0;
      hold2_q <= '0;
    end else if (rd_valid) begin
      hold1_q <= fresh1;
      hold2_q <= fresh2;
    end
  end

  assign rd_data1 = rd_valid ? fresh1 : hold1_q;
  assign rd_data2 = rd_valid ? fresh2 : hold2_q;

endmodule

// File: tb/tb_fmap_pool_buffer.sv
// Directed bench: 28x28x8 buffer with ReLU, plus two 4x4x2 buffers
// (ReLU on / off) sharing one stimulus for the small pooling cases.
module tb_fmap_pool_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        b_store, b_pool_start, b_load;
  logic [2:0]  b_ch_sel;
  logic [9:0]  b_w_addr, b_addr1, b_addr2;
  logic [7:0]  b_bias;
  logic [15:0] b_value;
  logic        b_busy, b_done, b_valid;
  logic [63:0] b_rd1, b_rd2;

  logic        s_store, s_pool_start, s_load;
  logic [0:0]  s_ch_sel;
  logic [3:0]  s_w_addr, s_addr1, s_addr2;
  logic [7:0]  s_bias;
  logic [15:0] s_value;
  logic        r_busy, r_done, r_valid, n_busy, n_done, n_valid;
  logic [15:0] r_rd1, r_rd2, n_rd1, n_rd2;

  int n_cmp = 0;
  int n_err = 0;

  fmap_pool_buffer #(.DATA_W(8), .VAL_W(16), .MAP_H(28), .MAP_W(28), .CH(8), .RELU(1)) u_big (
    .clk(clk), .rst(rst), .store(b_store), .ch_sel(b_ch_sel), .w_addr(b_w_addr),
    .bias(b_bias), .value(b_value), .pool_start(b_pool_start), .pool_busy(b_busy),
    .pool_done(b_done), .load(b_load), .addr1(b_addr1), .addr2(b_addr2),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .rd_valid(b_valid));

  fmap_pool_buffer #(.DATA_W(8), .VAL_W(16), .MAP_H(4), .MAP_W(4), .CH(2), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .store(s_store), .ch_sel(s_ch_sel), .w_addr(s_w_addr),
    .bias(s_bias), .value(s_value), .pool_start(s_pool_start), .pool_busy(r_busy),
    .pool_done(r_done), .load(s_load), .addr1(s_addr1), .addr2(s_addr2),
    .rd_data1(r_rd1), .rd_data2(r_rd2), .rd_valid(r_valid));

  fmap_pool_buffer #(.DATA_W(8), .VAL_W(16), .MAP_H(4), .MAP_W(4), .CH(2), .RELU(0)) u_raw (
    .clk(clk), .rst(rst), .store(s_store), .ch_sel(s_ch_sel), .w_addr(s_w_addr),
    .bias(s_bias), .value(s_value), .pool_start(s_pool_start), .pool_busy(n_busy),
    .pool_done(n_done), .load(s_load), .addr1(s_addr1), .addr2(s_addr2),
    .rd_data1(n_rd1), .rd_data2(n_rd2), .rd_valid(n_valid));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane(input logic [63:0] v, input int c);
    return v[c*8 +: 8];
  endfunction

  task automatic b_write(input int ch, input int addr, input int val, input int bs);
    b_store = 1'b1; b_ch_sel = 3'(ch); b_w_addr = 10'(addr);
    b_value = 16'(val); b_bias = 8'(bs);
    tick();
    b_store = 1'b0;
  endtask

  task automatic b_read(input int a1, input int a2);
    b_load = 1'b1; b_addr1 = 10'(a1); b_addr2 = 10'(a2);
    tick();
    b_load = 1'b0;
  endtask

  task automatic s_write(input int ch, input int addr, input int val);
    s_store = 1'b1; s_ch_sel = 1'(ch); s_w_addr = 4'(addr);
    s_value = 16'(val); s_bias = 8'd0;
    tick();
    s_store = 1'b0;
  endtask

  task automatic s_read(input int a1, input int a2);
    s_load = 1'b1; s_addr1 = 4'(a1); s_addr2 = 4'(a2);
    tick();
    s_load = 1'b0;
  endtask

  // Cycles counted from the edge that launches pool_start; stop_at < 0 runs to done
  task automatic b_pool(input bit disturb, input int stop_at, output int cycles);
    b_pool_start = 1'b1;
    tick();
    b_pool_start = 1'b0;
    cycles = 1;
    check_eq("busy_after_start", 64'(b_busy), 64'd1);
    while (!b_done && cycles < 3000 && cycles != stop_at) begin
      if (disturb) begin
        b_store = (cycles == 100); b_ch_sel = 3'd0; b_w_addr = 10'd783;
        b_value = 16'd100; b_bias = 8'd0;
        b_load = (cycles == 110); b_addr1 = 10'd783; b_addr2 = 10'd783;
        b_pool_start = (cycles == 120);
      end
      tick();
      cycles++;
      if (disturb && cycles == 111) check_eq("load_blocked_valid", 64'(b_valid), 64'd0);
    end
    b_store = 1'b0; b_load = 1'b0; b_pool_start = 1'b0;
  endtask

  int cyc;
  int sa [20] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15, 0, 1, 4, 5};
  int sv [20] = '{1, 5, -2, 3, 7, -1, 0, 2, -9, -4, -7, -6, 20, 30, 40, 50, -8, -3, -6, -5};

  initial begin
    rst = 1'b0;
    b_store = 0; b_pool_start = 0; b_load = 0; b_ch_sel = 0; b_w_addr = 0;
    b_addr1 = 0; b_addr2 = 0; b_bias = 0; b_value = 0;
    s_store = 0; s_pool_start = 0; s_load = 0; s_ch_sel = 0; s_w_addr = 0;
    s_addr1 = 0; s_addr2 = 0; s_bias = 0; s_value = 0;
    tick(); tick();

    check_eq("rst_busy", 64'(b_busy), 64'd0);
    check_eq("rst_done", 64'(b_done), 64'd0);
    check_eq("rst_valid", 64'(b_valid), 64'd0);
    check_eq("rst_rd1", b_rd1, 64'd0);
    check_eq("rst_rd2", b_rd2, 64'd0);
    check_eq("rst_small", {r_busy, r_done, r_valid, n_busy, n_done, n_valid}, 64'd0);
    rst = 1'b1;
    tick();

    // Saturating store
    b_write(0, 0, 200, 10);
    b_write(0, 1, -300, -5);
    b_write(0, 2, 5, -3);
    b_read(0, 1);
    check_eq("sat_pos", 64'(lane(b_rd1, 0)), 64'h7f);
    check_eq("sat_neg", 64'(lane(b_rd2, 0)), 64'h80);
    b_read(2, 2);
    check_eq("sat_none", 64'(lane(b_rd1, 0)), 64'h02);

    // Read latency, out-of-range port, hold
    b_write(3, 100, 42, 0);
    b_load = 1'b1; b_addr1 = 10'd100; b_addr2 = 10'd900;
    #2;
    check_eq("valid_before_edge", 64'(b_valid), 64'd0);
    tick();
    b_load = 1'b0;
    check_eq("valid_after_load", 64'(b_valid), 64'd1);
    check_eq("rd1_ch3", 64'(lane(b_rd1, 3)), 64'd42);
    check_eq("rd2_oob", b_rd2, 64'd0);
    tick();
    check_eq("valid_drop", 64'(b_valid), 64'd0);
    check_eq("rd1_hold", 64'(lane(b_rd1, 3)), 64'd42);

    // Full pool with blocked traffic mid-run; last window feeds addr 195
    b_write(0, 754, 10, 0);  b_write(0, 755, -7, 0);
    b_write(0, 782, 33, 0);  b_write(0, 783, 12, 0);
    b_write(5, 754, -20, 0); b_write(5, 755, -30, 0);
    b_write(5, 782, -4, 0);  b_write(5, 783, -9, 0);
    b_pool(1'b1, -1, cyc);
    check_eq("pool_latency", 64'(cyc), 64'd1177);
    check_eq("busy_falls_with_done", 64'(b_busy), 64'd0);
    tick();
    check_eq("done_one_cycle", 64'(b_done), 64'd0);
    b_read(195, 195);
    check_eq("pool_ch0", 64'(lane(b_rd1, 0)), 64'd33);
    check_eq("pool_ch5_relu", 64'(lane(b_rd2, 5)), 64'd0);

    // Reset partway through a pool, then a clean pool
    b_pool(1'b0, 300, cyc);
    rst = 1'b0;
    tick();
    check_eq("midrst_busy", 64'(b_busy), 64'd0);
    check_eq("midrst_done", 64'(b_done), 64'd0);
    rst = 1'b1;
    tick();
    b_pool(1'b0, -1, cyc);
    check_eq("pool_latency_after_rst", 64'(cyc), 64'd1177);

    // Small 4x4x2 maps, ReLU on and off
    for (int i = 0; i < 20; i++) s_write((i < 16) ? 0 : 1, sa[i], sv[i]);
    s_pool_start = 1'b1; s_store = 1'b1; s_ch_sel = 1'd0; s_w_addr = 4'd15;
    s_value = 16'd99; s_bias = 8'd0;
    tick();
    s_pool_start = 1'b0; s_store = 1'b0;
    cyc = 1;
    while (!r_done && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("small_latency", 64'(cyc), 64'd25);
    check_eq("small_done_raw", 64'(n_done), 64'd1);
    tick();
    s_read(0, 1);
    check_eq("relu_addr0", 64'(r_rd1), 64'h0005);
    check_eq("raw_addr0", 64'(n_rd1), 64'hfd05);
    check_eq("relu_addr1_ch0", 64'(r_rd2[7:0]), 64'h07);
    check_eq("small_valid", 64'({r_valid, n_valid}), 64'd3);
    s_read(2, 3);
    check_eq("relu_addr2_ch0", 64'(r_rd1[7:0]), 64'h00);
    check_eq("raw_addr2_ch0", 64'(n_rd1[7:0]), 64'hfc);
    check_eq("relu_addr3_ch0", 64'(r_rd2[7:0]), 64'h32);
    check_eq("raw_addr3_ch0", 64'(n_rd2[7:0]), 64'h32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fmap_pool_buffer.md
# fmap_pool_buffer

Parametrised per-channel feature-map buffer for the convolution datapath. Stores biased, saturated convolution results into one bank per output channel. On request, runs an FSM-driven 2x2/stride-2 max-pool with optional ReLU across all channels in parallel, writing the pooled map compacted in place. Serves two registered read ports per channel to the next layer. It replaces the fixed 28x28x8 layer-1 buffer and scales to later layers.

## Interface
- DATA_W, 8: signed stored sample width
- VAL_W, 16: signed width of incoming convolution value
- MAP_H, 28: input map rows
- MAP_W, 28: input map columns
- CH, 8: channel (bank) count
- RELU, 1: 1 clamps pooled result at 0; 0 passes the raw max
- Derived: DEPTH = MAP_H*MAP_W, AW = $clog2(DEPTH), CW = $clog2(CH) (min 1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- store  in  1  write strobe
- ch_sel  in  CW  target bank for store
- w_addr  in  AW  write address (row*MAP_W+col)
- bias  in  DATA_W  signed bias added on store
- value  in  VAL_W  signed convolution result
- pool_start  in  1  one-cycle request to pool all banks
- pool_busy  out  1  high from the cycle after accepted start until done
- pool_done  out  1  one-cycle pulse when pooling completes
- load  in  1  read strobe
- addr1, addr2  in  AW  read addresses, same for all banks
- rd_data1, rd_data2  out  CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- rd_valid  out  1  rd_data valid (one cycle after load)

## Operation
- Store: when store=1, pool_busy=0, w_addr<DEPTH and ch_sel<CH: bank[ch_sel][w_addr] <= sat(value+bias). The sum is computed at max(VAL_W,DATA_W)+1 bits and saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. All other stores are dropped.
- Load: when load=1 and pool_busy=0, both ports read all banks. An address >= DEPTH returns 0. Load during busy is ignored, and rd_valid stays 0.
- Pool FSM states: IDLE, RD0, RD1, RD2, RD3, CMP, WR.
  - IDLE->RD0 on pool_start.
  - RDk issues a read of window element k: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - Data arrives one cycle later and updates a running max per channel. RD0 data initialises the max.
  - CMP absorbs the final read.
  - WR writes max (or max(0,max) when RELU=1) to address r*(MAP_W/2)+c.
  - WR->RD0 for the next window, or WR->IDLE with pool_done=1 after the last window.
- Window order is row-major, r over 0..MAP_H/2-1 and c over 0..MAP_W/2-1. An odd final row or column is discarded.
- In-place compaction is safe because a destination address is always <= the lowest source address of the current window.
- pool_start while busy is ignored. Store and pool_start in the same cycle: the store is dropped.
- Reset mid-pool returns to IDLE and clears counters. Bank contents are not cleared and are undefined after an interrupted pool.

## Timing
- Reset values: pool_busy=0, pool_done=0, rd_valid=0, rd_data1=rd_data2=0.
- Store write takes effect at the clock edge, so data is readable by a load in the next cycle.
- Read latency is 1: rd_valid and rd_data update one cycle after load. rd_data holds its value when load=0.
- Pool: 6 cycles per window. pool_done rises (MAP_H/2)*(MAP_W/2)*6 + 1 cycles after the pool_start edge. For 28x28 that is 1177 cycles.
- pool_busy falls in the same cycle pool_done pulses.

## Structure
- Shared package cnn_pkg holds:
  - sat_add function (parametrised widths)
  - window-offset constants
  - pool FSM state enum
- Sub-module fmap_bank, instantiated CH times: synchronous RAM with 1 write port and 2 read ports, depth DEPTH, width DATA_W, ram_style block.
  - Read port A is muxed between load addr1 and the pool read address.
  - The write port is muxed between the store and the pool WR state.

## Test plan
- Store saturation, DATA_W=8: value=200, bias=10 -> stored 127; value=-300, bias=-5 -> -128; value=5, bias=-3 -> 2.
- Read: store ch3 addr 100 = 42, then load addr1=100, addr2=900 -> rd_data1[ch3]=42, rd_data2=0, rd_valid one cycle later.
- Pool, 4x4 map with CH=2 and RELU=1. Ch0 window0 = {1,5,-2,3} -> addr0=5. Ch1 window0 all negative -> 0. With RELU=0, ch1 -> the max negative value.
- Full 28x28 pool: pool_done exactly 1177 cycles after start. Pooled addr 195 = max of inputs 754, 755, 782, 783.
- Busy blocking: pool_start, store and load mid-pool -> no write and rd_valid=0. A second pool_start is ignored and timing is unchanged.
- Reset at cycle 300 of a pool -> next cycle pool_busy=0 and pool_done=0. A fresh pool_start then completes on normal timing.
